// File: rtl/ibus_fetch_ctrl.sv
// Instruction-bus fetch controller.
// Serves fetch requests from a one-entry 64-bit line buffer and turns misses
// into 8-byte-aligned memory reads. One memory read is outstanding at most.
// A flush invalidates the buffer and marks any in-flight read as stale, so
// its data is thrown away when it returns.
module ibus_fetch_ctrl #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        flush,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        buf_valid_q, buf_valid_d;
  logic [60:0] buf_tag_q, buf_tag_d;
  logic [63:0] buf_data_q, buf_data_d;
  logic [60:0] pend_tag_q, pend_tag_d;
  logic        drop_q, drop_d;
  logic        hit;

  // The low two address bits are always zero for a valid fetch; only
  // the word-select bit and the doubleword tag matter here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^ireq_addr[1:0];

  // Buffer hit: only answered from IDLE, so a hit never overlaps a fill.
  assign hit = !reset && (state_q == IDLE) && ireq_valid && buf_valid_q &&
               (buf_tag_q == ireq_addr[63:3]) && !flush;

  // Zero-latency response path and the memory request, all forced low in reset.
  always_comb begin
    iresp_data_ok = hit;
    iresp_addr_ok = hit;
    iresp_data    = 32'h0;
    if (hit) begin
      iresp_data = ireq_addr[2] ? buf_data_q[63:32] : buf_data_q[31:0];
    end
    mem_req_valid = !reset && (state_q == REQ);
    mem_req_addr  = mem_req_valid ? {pend_tag_q, 3'b000} : 64'h0;
  end

  // Next-state logic: miss issue, request handshake, fill or discard.
  always_comb begin
    state_d     = state_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    pend_tag_d  = pend_tag_q;
    drop_d      = drop_q;
    case (state_q)
      IDLE: begin
        if (ireq_valid && !hit && !flush) begin
          state_d    = REQ;
          pend_tag_d = ireq_addr[63:3];
          drop_d     = 1'b0;
        end
      end
      REQ: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (mem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (flush) begin
          drop_d = 1'b1;
        end
        if (mem_resp_valid) begin
          state_d = IDLE;
          if (!drop_q && !flush) begin
            buf_data_d  = mem_resp_data;
            buf_tag_d   = pend_tag_q;
            buf_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      buf_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; the tag starts at the reset PC
  // but the buffer is marked empty, so the tag value is never used.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= RESET_PC[63:3];
      buf_data_q  <= 64'h0;
      pend_tag_q  <= 61'h0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      pend_tag_q  <= pend_tag_d;
      drop_q      <= drop_d;
    end
  end

endmodule

// File: doc/ibus_fetch_ctrl.md
Name: ibus_fetch_ctrl

Overview:
Instruction-bus controller directly upstream of the fetch stage. It serves fetch's instruction requests (valid, addr) with 32-bit instructions and a data_ok handshake. It converts fetch misses into 8-byte-aligned memory reads and keeps a one-entry 64-bit line buffer, so sequential fetches within one doubleword return in zero cycles. It drops stale responses after a pipeline flush (CSR redirect, fence.i).

Parameters:
RESET_PC, 64'h8000_0000, address pre-tagged as invalid at reset (buffer starts empty regardless; documentation only, no functional effect)

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
ireq_valid  input  1  fetch request valid; low for misaligned pc
ireq_addr  input  64  fetch byte address, addr[1:0]==0 when valid
iresp_addr_ok  output  1  request accepted (equals iresp_data_ok)
iresp_data_ok  output  1  iresp_data valid this cycle
iresp_data  output  32  instruction word
flush  input  1  pipeline flush: invalidate buffer, drop outstanding response
mem_req_valid  output  1  memory read request
mem_req_addr  output  64  read address, bits[2:0]==0
mem_req_ready  input  1  memory accepts request this cycle
mem_resp_valid  input  1  read data returned (single beat)
mem_resp_data  input  64  read doubleword

Behaviour:
- State: FSM {IDLE, REQ, WAIT}; buf_valid, buf_tag[60:0]=addr[63:3], buf_data[63:0]; pend_tag[60:0]; drop flag.
- Reset: state IDLE, buf_valid=0, drop=0, pend_tag=0. All outputs 0 during and after reset until a request arrives.
- Hit: state==IDLE && ireq_valid && buf_valid && buf_tag==ireq_addr[63:3] && !flush.
  - Combinational in the same cycle: iresp_data_ok=iresp_addr_ok=1.
  - iresp_data = ireq_addr[2] ? buf_data[63:32] : buf_data[31:0].
  - This is zero latency, because fetch samples data_ok in the cycle it issues.
- At all other times iresp_data_ok=0 and iresp_data=0.
- Miss: IDLE && ireq_valid && !hit && !flush → next state REQ, pend_tag<=ireq_addr[63:3], drop<=0.
- REQ:
  - mem_req_valid=1, mem_req_addr={pend_tag,3'b000}, both registered and stable until mem_req_ready.
  - The request is never withdrawn once raised.
  - mem_req_ready → WAIT.
- WAIT: on mem_resp_valid → IDLE.
  - drop==0 and no flush this cycle: buf_data<=mem_resp_data, buf_tag<=pend_tag, buf_valid<=1.
  - Otherwise the response is discarded and the buffer is left untouched.
- Miss latency: request at cycle t → mem_req_valid at t+1. With ready at t+1 and response at cycle r, data_ok (via hit) at r+1 provided fetch still presents the same doubleword.
- Address change/withdrawal during REQ/WAIT (fetch branch redirect): not stale. The line still fills the buffer. The new address is handled in IDLE after completion (hit or new miss).
- flush:
  - Any state: buf_valid<=0 in the same edge.
  - In REQ or WAIT: drop<=1. The handshake completes, the response is discarded, then IDLE.
  - In IDLE: no hit and no new miss that cycle.
- flush and mem_resp_valid in the same WAIT cycle: response discarded, buf_valid=0.
- flush and mem_req_ready in the same REQ cycle: → WAIT with drop=1.
- mem_resp_valid outside WAIT is ignored (protocol error, no state change).
- Only one outstanding memory request at a time.
- Reset mid-transaction: FSM returns to IDLE. A later mem_resp_valid arriving in IDLE is ignored.

Test Plan:
- Cold fetch 0x8000_0000 (ready same cycle, resp 3 cycles later, data 0x0000_0013_0000_0093):
  - mem_req_addr=0x8000_0000 one cycle after request.
  - data_ok=1 with data 0x0000_0093 the cycle after the response.
- Sequential hit:
  - Addr 0x8000_0004 next → data_ok same cycle, data 0x0000_0013, no mem_req.
  - 0x8000_0008 → miss, mem_req_addr=0x8000_0008.
- Backpressure: mem_req_ready low for 5 cycles → mem_req_valid and addr held constant for 5 cycles, single accept.
- Flush in WAIT (response arrives 2 cycles later with 0xDEAD_BEEF_DEAD_BEEF):
  - Response dropped, buf_valid=0.
  - Re-request of the same address issues a new mem_req; no data_ok with stale data.
- Redirect during WAIT to 0x8000_1000: old line fills the buffer, then a new mem_req for 0x8000_1000. Returning to the old doubleword later hits.
- Reset asserted in WAIT, then mem_resp_valid: FSM IDLE, buf_valid=0, data_ok stays 0 and buffer unchanged.
